// File: rtl/tone_pkg.sv
// Shared definitions for the buzzer transmitter and the tone detector, so that
// both sides use one note table and one code format.
package tone_pkg;

   localparam int unsigned NUM_NOTES = 7;

   // Note number 1..7; 0 means silent or not locked.
   typedef logic [3:0] note_t;

   // Note plus octave, packed as {octave_low, note}.
   typedef logic [4:0] code_t;

   localparam note_t NOTE_SILENT = 4'd0;

   // Half-period in 100 MHz clocks for each note of the base octave.
   localparam logic [31:0] HP_BASE [1:7] = '{
      32'd381681, 32'd340137, 32'd303031, 32'd285715,
      32'd255103, 32'd227274, 32'd202430
   };

   typedef enum logic [1:0] {
      SILENT,
      ARMED,
      CONFIRM,
      LOCKED
   } tone_state_e;

   function automatic code_t make_code(input logic low, input note_t note);
      return {low, note};
   endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Front end of the tone detector: synchronizes the asynchronous tone line,
// flags both edges and counts clocks between them, saturating at the timeout.
module tone_period_meter #(
   parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        tone_in,
   output logic        edge_pulse,
   output logic [31:0] measured,
   output logic        timeout
);

   localparam logic [31:0] TIMEOUT_V = 32'(TIMEOUT_CYC);

   // [0] and [1] form the synchronizer, [2] holds the previous synced level.
   logic [2:0]  sync_q, sync_d;
   logic [31:0] cnt_q, cnt_d;

   // The synchronizer keeps shifting while disabled, so re-enabling never
   // produces an edge that did not happen on the pin.
   always_comb sync_d = {sync_q[1:0], tone_in};

   assign edge_pulse = enable && (sync_q[1] ^ sync_q[2]);
   assign measured   = cnt_q + 32'd1;
   assign timeout    = enable && (cnt_q == TIMEOUT_V);

   // Clocks since the last edge, cleared on an edge or while disabled.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      cnt_d = cnt_q;
      if (!enable || edge_pulse) begin
         cnt_d = '0;
      end else if (cnt_q != TIMEOUT_V) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, independent of statement order.
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/tone_detector.sv
// Decodes the buzzer square wave into note 1..7 plus octave. Each measured
// half-period is classified against the note table; a note is reported once
// STABLE_CNT consecutive half-periods agree, and cleared on silence.
// HP_SHIFT divides the whole note table by 2**HP_SHIFT for a faster tone
// clock; 0 gives the real 100 MHz timing.
module tone_detector
   import tone_pkg::*;
#(
   parameter int unsigned TOL_SHIFT   = 6,
   parameter int unsigned STABLE_CNT  = 4,
   parameter int unsigned TIMEOUT_CYC = 2_000_000,
   parameter int unsigned HP_SHIFT    = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        tone_in,
   output logic [3:0]  note_out,
   output logic        octave_low,
   output logic        note_valid,
   output logic        note_change,
   output logic [31:0] half_period
);

   localparam logic [3:0] STABLE_V = 4'(STABLE_CNT);

   logic        edge_pulse;
   logic        timeout;
   logic [31:0] measured;

   tone_period_meter #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_meter (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .tone_in    (tone_in),
      .edge_pulse (edge_pulse),
      .measured   (measured),
      .timeout    (timeout)
   );

   logic        match_hit;
   code_t       match_code;

   tone_state_e state_q, state_d;
   code_t       cand_q, cand_d;
   logic [3:0]  stab_q, stab_d;
   code_t       out_q, out_d;
   logic        valid_q, valid_d;
   logic        change_q, change_d;
   logic [31:0] hp_q, hp_d;

   // Classifier: scan from the highest index down so the lowest matching
   // index (base octave, then lower note number) is the one kept.
   always_comb begin
      logic [31:0] exp_v, tol_v, diff_v;
      match_hit  = 1'b0;
      match_code = '0;
      exp_v      = '0;
      tol_v      = '0;
      diff_v     = '0;
      for (int oct = 1; oct >= 0; oct--) begin
         for (int k = NUM_NOTES; k >= 1; k--) begin
            exp_v  = (HP_BASE[k] << oct) >> HP_SHIFT;
            tol_v  = exp_v >> TOL_SHIFT;
            diff_v = (measured >= exp_v) ? (measured - exp_v) : (exp_v - measured);
            if (diff_v <= tol_v) begin
               match_hit  = 1'b1;
               match_code = make_code(oct == 1, note_t'(k));
            end
         end
      end
   end

   // Lock FSM and output register next-state; an edge takes priority over a
   // timeout in the same cycle.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      stab_d  = stab_q;
      out_d   = out_q;
      valid_d = valid_q;
      hp_d    = edge_pulse ? measured : hp_q;

      if (!enable) begin
         state_d = SILENT;
         cand_d  = '0;
         stab_d  = '0;
         out_d   = '0;
         valid_d = 1'b0;
         hp_d    = '0;
      end else if (edge_pulse) begin
         unique case (state_q)
            SILENT: state_d = ARMED;
            ARMED: begin
               if (match_hit) begin
                  state_d = CONFIRM;
                  cand_d  = match_code;
                  stab_d  = 4'd1;
               end
            end
            CONFIRM: begin
               if (!match_hit) begin
                  state_d = ARMED;
               end else if (match_code == cand_q) begin
                  stab_d = stab_q + 4'd1;
                  if (stab_q + 4'd1 == STABLE_V) begin
                     state_d = LOCKED;
                     out_d   = cand_q;
                     valid_d = 1'b1;
                  end
               end else begin
                  cand_d = match_code;
                  stab_d = 4'd1;
               end
            end
            LOCKED: begin
               if (!match_hit) begin
                  state_d = ARMED;
               end else if (match_code != out_q) begin
                  state_d = CONFIRM;
                  cand_d  = match_code;
                  stab_d  = 4'd1;
               end
            end
            default: state_d = SILENT;
         endcase
      end else if (timeout && state_q != SILENT) begin
         state_d = SILENT;
         cand_d  = '0;
         stab_d  = '0;
         out_d   = '0;
         valid_d = 1'b0;
      end

      change_d = {valid_d, out_d} != {valid_q, out_q};
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SILENT;
         cand_q   <= '0;
         stab_q   <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
         change_q <= 1'b0;
         hp_q     <= '0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         stab_q   <= stab_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         change_q <= change_d;
         hp_q     <= hp_d;
      end
   end

   assign note_out    = out_q[3:0];
   assign octave_low  = out_q[4];
   assign note_valid  = valid_q;
   assign note_change = change_q;
   assign half_period = hp_q;

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector. The note table is scaled by 2**9, so the
// half-periods used here are: note1 745, note2 664, note3 591 (window 9),
// note5-low 996, note7 395. Silence timeout is 3000 clocks.
module tb_tone_detector;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        enable  = 1'b0;
   logic        tone_in = 1'b0;
   logic [3:0]  note_out;
   logic        octave_low;
   logic        note_valid;
   logic        note_change;
   logic [31:0] half_period;

   int n_cmp    = 0;
   int n_bad    = 0;
   int n_change = 0;
   int since    = 0;
   int c0;

   tone_detector #(
      .TOL_SHIFT   (6),
      .STABLE_CNT  (4),
      .TIMEOUT_CYC (3000),
      .HP_SHIFT    (9)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .tone_in     (tone_in),
      .note_out    (note_out),
      .octave_low  (octave_low),
      .note_valid  (note_valid),
      .note_change (note_change),
      .half_period (half_period)
   );

   always #5 clk = ~clk;

   // Count note_change pulses, sampled mid-cycle.
   always @(negedge clk) if (note_change) n_change++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 200000 cycles");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input int note, input int oct, input int valid);
      check({tag, ".note"},  32'(note_out),   32'(note));
      check({tag, ".oct"},   32'(octave_low), 32'(oct));
      check({tag, ".valid"}, 32'(note_valid), 32'(valid));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      since += n;
   endtask

   task automatic toggle_now();
      @(negedge clk);
      tone_in = ~tone_in;
      since   = 0;
   endtask

   // Toggle so that exactly n clocks separate this toggle from the previous one.
   task automatic toggle_at(input int n);
      if (n > since) repeat (n - since) @(negedge clk);
      tone_in = ~tone_in;
      since   = 0;
   endtask

   task automatic tone(input int n, input int count);
      for (int i = 0; i < count; i++) toggle_at(n);
   endtask

   task automatic restart();
      tone_in = 1'b0;
      enable  = 1'b1;
      idle(4);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(4);
   endtask

   initial begin
      // Reset state
      idle(3);
      expect_out("reset", 0, 0, 0);
      check("reset.chg", 32'(note_change), 32'd0);
      check("reset.hp", half_period, 32'd0);

      // 1: note 3 locks on the 5th edge, one change pulse
      restart();
      c0 = n_change;
      toggle_now();
      tone(591, 3);
      idle(5);
      expect_out("t1_pre", 0, 0, 0);
      toggle_at(591);
      idle(5);
      expect_out("t1_lock", 3, 0, 1);
      check("t1_hp", half_period, 32'd591);
      toggle_at(591);
      idle(5);
      expect_out("t1_hold", 3, 0, 1);
      check("t1_chg", 32'(n_change - c0), 32'd1);

      // 2: note 5 low octave, then note 7 with old note held meanwhile
      restart();
      c0 = n_change;
      toggle_now();
      tone(996, 4);
      idle(5);
      expect_out("t2_low5", 5, 1, 1);
      tone(395, 3);
      idle(5);
      expect_out("t2_held", 5, 1, 1);
      toggle_at(395);
      idle(5);
      expect_out("t2_n7", 7, 0, 1);
      check("t2_chg", 32'(n_change - c0), 32'd2);

      // 3: just outside the window stays unlocked; just inside locks
      restart();
      toggle_now();
      tone(601, 5);
      idle(5);
      expect_out("t3_out", 0, 0, 0);
      check("t3_hp_out", half_period, 32'd601);
      tone(598, 3);
      idle(5);
      expect_out("t3_in_pre", 0, 0, 0);
      toggle_at(598);
      idle(5);
      expect_out("t3_in", 3, 0, 1);
      check("t3_hp_in", half_period, 32'd598);

      // 4: silence timeout clears a locked note
      restart();
      c0 = n_change;
      toggle_now();
      tone(745, 4);
      idle(5);
      expect_out("t4_lock", 1, 0, 1);
      idle(2990);
      expect_out("t4_before", 1, 0, 1);
      idle(15);
      expect_out("t4_silent", 0, 0, 0);
      check("t4_chg", 32'(n_change - c0), 32'd2);

      // 5: alternating notes never lock
      restart();
      c0 = n_change;
      toggle_now();
      for (int i = 0; i < 4; i++) begin
         toggle_at(745);
         toggle_at(664);
      end
      idle(5);
      expect_out("t5", 0, 0, 0);
      check("t5_chg", 32'(n_change - c0), 32'd0);

      // 6a: asynchronous reset mid-lock, then relock from scratch
      restart();
      toggle_now();
      tone(591, 5);
      idle(5);
      expect_out("t6_lock", 3, 0, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 expect_out("t6_async", 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      since += 2;
      toggle_now();
      tone(591, 3);
      idle(5);
      expect_out("t6_rst_pre", 0, 0, 0);
      toggle_at(591);
      idle(5);
      expect_out("t6_rst_lock", 3, 0, 1);

      // 6b: one-clock disable behaves like a reset
      c0 = n_change;
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      since += 2;
      idle(1);
      expect_out("t6_dis", 0, 0, 0);
      check("t6_dis_chg", 32'(n_change - c0), 32'd1);
      toggle_at(591);
      tone(591, 3);
      idle(5);
      expect_out("t6_en_pre", 0, 0, 0);
      toggle_at(591);
      idle(5);
      expect_out("t6_en_lock", 3, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
